// File: rtl/riscv_pkg.sv
// Shared RISC-V execute-stage types: ALU op classes, forwarding selects, funct3 codes.
package riscv_pkg;

  localparam int XLEN_DEFAULT = 64;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_BR    = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  // 2'b11 is not an encoding; it falls back to the register file.
  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_WB    = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_t;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/ex_mem_stage_if.sv
// ID/EX -> EX/MEM bundle. Branch statistic counters exist only when
// EX_BRANCH_STATS_EN is defined.
interface ex_mem_if #(parameter int XLEN = 64);
  logic [XLEN-1:0] a_in;
  logic [XLEN-1:0] readdata1_in;
  logic [XLEN-1:0] readdata2_in;
  logic [XLEN-1:0] imm_data_in;
  logic [4:0]      rd_in;
  logic [3:0]      funct4_in;
  logic [1:0]      aluop_in;
  logic            branch_in;
  logic            memread_in;
  logic            memtoreg_in;
  logic            memwrite_in;
  logic            regwrite_in;
  logic            alusrc_in;
  logic [1:0]      forward_a;
  logic [1:0]      forward_b;
  logic [XLEN-1:0] wb_data;
  logic            stall;
  logic            flush;

  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] store_data;
  logic [4:0]      rd;
  logic [XLEN-1:0] branch_target;
  logic            pc_src;
  logic            flush_out;
  logic            zero;
  logic            Memread;
  logic            Memtoreg;
  logic            Memwrite;
  logic            Regwrite;
`ifdef EX_BRANCH_STATS_EN
  logic [31:0]     branch_count;
  logic [31:0]     taken_count;
`endif

`ifdef EX_BRANCH_STATS_EN
  modport master (
    output a_in, readdata1_in, readdata2_in, imm_data_in, rd_in, funct4_in, aluop_in,
           branch_in, memread_in, memtoreg_in, memwrite_in, regwrite_in, alusrc_in,
           forward_a, forward_b, wb_data, stall, flush,
    input  alu_result, store_data, rd, branch_target, pc_src, flush_out, zero,
           Memread, Memtoreg, Memwrite, Regwrite, branch_count, taken_count
  );
  modport slave (
    input  a_in, readdata1_in, readdata2_in, imm_data_in, rd_in, funct4_in, aluop_in,
           branch_in, memread_in, memtoreg_in, memwrite_in, regwrite_in, alusrc_in,
           forward_a, forward_b, wb_data, stall, flush,
    output alu_result, store_data, rd, branch_target, pc_src, flush_out, zero,
           Memread, Memtoreg, Memwrite, Regwrite, branch_count, taken_count
  );
`else
  modport master (
    output a_in, readdata1_in, readdata2_in, imm_data_in, rd_in, funct4_in, aluop_in,
           branch_in, memread_in, memtoreg_in, memwrite_in, regwrite_in, alusrc_in,
           forward_a, forward_b, wb_data, stall, flush,
    input  alu_result, store_data, rd, branch_target, pc_src, flush_out, zero,
           Memread, Memtoreg, Memwrite, Regwrite
  );
  modport slave (
    input  a_in, readdata1_in, readdata2_in, imm_data_in, rd_in, funct4_in, aluop_in,
           branch_in, memread_in, memtoreg_in, memwrite_in, regwrite_in, alusrc_in,
           forward_a, forward_b, wb_data, stall, flush,
    output alu_result, store_data, rd, branch_target, pc_src, flush_out, zero,
           Memread, Memtoreg, Memwrite, Regwrite
  );
`endif
endinterface

// File: rtl/ex_mem_stage_alu64.sv
// Combinational execute-stage ALU; shifts use only the low SHAMT_W bits of b.
module alu64
  import riscv_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int SHAMT_W = 6
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [1:0]      aluop,
  input  logic [3:0]      funct4,
  input  logic            alusrc,
  output logic [XLEN-1:0] result
);

  logic [SHAMT_W-1:0]     shamt;
  logic signed [XLEN-1:0] a_s;

  assign shamt = b[SHAMT_W-1:0];
  assign a_s   = a;

  always_comb begin
    result = '0;
    case (aluop_t'(aluop))
      ALUOP_ADD: result = a + b;
      ALUOP_BR:  result = a - b;
      ALUOP_FUNCT: begin
        case (funct4[2:0])
          // instr[30] also appears on I-type immediates, so only R-type subtracts
          F3_ADD_SUB: result = (funct4[3] && !alusrc) ? a - b : a + b;
          F3_SLL:     result = a << shamt;
          F3_XOR:     result = a ^ b;
          F3_SRL_SRA: result = funct4[3] ? $unsigned(a_s >>> shamt) : a >> shamt;
          F3_OR:      result = a | b;
          F3_AND:     result = a & b;
          default:    result = '0;
        endcase
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage and EX/MEM register: forwarding, ALU, branch resolve, registered redirect.
// Defining EX_BRANCH_STATS_EN adds branch_count/taken_count statistic counters.
module ex_mem_stage
  import riscv_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int SHAMT_W = 6
) (
  input  logic   clk,
  input  logic   reset,
  ex_mem_if.slave bus
);

  logic [XLEN-1:0]        op_a_p0, op_bf_p0, op_b_p0, alu_res_p0, target_p0;
  logic signed [XLEN-1:0] op_a_s_p0, op_bf_s_p0;
  logic                   cond_p0, taken_p0, load_p0, keep_ctrl_p0;

  logic [XLEN-1:0] alu_result_p1, store_data_p1, target_p1;
  logic [4:0]      rd_p1;
  logic            pc_src_p1, zero_p1;
  logic            memread_p1, memtoreg_p1, memwrite_p1, regwrite_p1;

  // ---- p0: operand select, ALU, branch compare ----
  always_comb begin
    case (fwd_sel_t'(bus.forward_a))
      FWD_EXMEM: op_a_p0 = alu_result_p1;
      FWD_WB:    op_a_p0 = bus.wb_data;
      default:   op_a_p0 = bus.readdata1_in;
    endcase
    case (fwd_sel_t'(bus.forward_b))
      FWD_EXMEM: op_bf_p0 = alu_result_p1;
      FWD_WB:    op_bf_p0 = bus.wb_data;
      default:   op_bf_p0 = bus.readdata2_in;
    endcase
  end

  assign op_b_p0    = bus.alusrc_in ? bus.imm_data_in : op_bf_p0;
  assign op_a_s_p0  = op_a_p0;
  assign op_bf_s_p0 = op_bf_p0;
  assign target_p0  = bus.a_in + (bus.imm_data_in << 1);

  alu64 #(.XLEN(XLEN), .SHAMT_W(SHAMT_W)) u_alu (
    .a      (op_a_p0),
    .b      (op_b_p0),
    .aluop  (bus.aluop_in),
    .funct4 (bus.funct4_in),
    .alusrc (bus.alusrc_in),
    .result (alu_res_p0)
  );

  // Branches compare against the forwarded register value, never the immediate.
  always_comb begin
    cond_p0 = 1'b0;
    case (bus.funct4_in[2:0])
      F3_BEQ:  cond_p0 = (op_a_p0 == op_bf_p0);
      F3_BNE:  cond_p0 = (op_a_p0 != op_bf_p0);
      F3_BLT:  cond_p0 = (op_a_s_p0 < op_bf_s_p0);
      F3_BGE:  cond_p0 = (op_a_s_p0 >= op_bf_s_p0);
      F3_BLTU: cond_p0 = (op_a_p0 < op_bf_p0);
      F3_BGEU: cond_p0 = (op_a_p0 >= op_bf_p0);
      default: cond_p0 = 1'b0;
    endcase
  end

  assign taken_p0     = bus.branch_in & cond_p0;
  assign load_p0      = bus.flush | ~bus.stall;
  assign keep_ctrl_p0 = ~bus.flush;

  // ---- p1: EX/MEM register (flush beats stall; a flushed slot cannot redirect) ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_result_p1 <= '0;
      store_data_p1 <= '0;
      target_p1     <= '0;
      rd_p1         <= '0;
      zero_p1       <= 1'b0;
      pc_src_p1     <= 1'b0;
      memread_p1    <= 1'b0;
      memtoreg_p1   <= 1'b0;
      memwrite_p1   <= 1'b0;
      regwrite_p1   <= 1'b0;
    end else if (load_p0) begin
      alu_result_p1 <= alu_res_p0;
      store_data_p1 <= op_bf_p0;
      target_p1     <= target_p0;
      rd_p1         <= bus.rd_in;
      zero_p1       <= (alu_res_p0 == '0);
      pc_src_p1     <= taken_p0 & keep_ctrl_p0;
      memread_p1    <= bus.memread_in & keep_ctrl_p0;
      memtoreg_p1   <= bus.memtoreg_in & keep_ctrl_p0;
      memwrite_p1   <= bus.memwrite_in & keep_ctrl_p0;
      regwrite_p1   <= bus.regwrite_in & keep_ctrl_p0;
    end
  end

  assign bus.alu_result    = alu_result_p1;
  assign bus.store_data    = store_data_p1;
  assign bus.branch_target = target_p1;
  assign bus.rd            = rd_p1;
  assign bus.zero          = zero_p1;
  assign bus.pc_src        = pc_src_p1;
  assign bus.flush_out     = pc_src_p1;
  assign bus.Memread       = memread_p1;
  assign bus.Memtoreg      = memtoreg_p1;
  assign bus.Memwrite      = memwrite_p1;
  assign bus.Regwrite      = regwrite_p1;

`ifdef EX_BRANCH_STATS_EN
  logic [31:0] branch_cnt_p1, taken_cnt_p1;
  logic        count_en_p0;

  assign count_en_p0 = bus.branch_in & ~bus.flush & ~bus.stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch_cnt_p1 <= '0;
      taken_cnt_p1  <= '0;
    end else if (count_en_p0) begin
      branch_cnt_p1 <= branch_cnt_p1 + 32'd1;
      if (cond_p0) taken_cnt_p1 <= taken_cnt_p1 + 32'd1;
    end
  end

  assign bus.branch_count = branch_cnt_p1;
  assign bus.taken_count  = taken_cnt_p1;
`endif

endmodule
